// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: memory request packet and arbiter FSM states.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first asserted request searching upward from rr_ptr, wrapping.
module rr_priority_picker #(
  parameter int unsigned NUM_PORTS = 4,
  localparam int unsigned IDX_W = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic                 valid,
  output logic [IDX_W-1:0]     winner
);

  int unsigned k;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    k      = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      k = 32'(rr_ptr) + i;
      if (k >= NUM_PORTS) k = k - NUM_PORTS;
      if (!valid && req[IDX_W'(k)]) begin
        valid  = 1'b1;
        winner = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter granting one port at a time access to a single-port data memory,
// with optional bounded hold for atomic multi-cycle sequences.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned MAX_HOLD  = 8,
  localparam int unsigned IDX_W = $clog2(NUM_PORTS),
  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] hold,
  input  mem_req_t             mem_req_in [NUM_PORTS],
  input  logic [DATA_W-1:0]    mem_rdata,
  output mem_req_t             mem_req_out,
  output logic [NUM_PORTS-1:0] grant,
  output logic [DATA_W-1:0]    rdata [NUM_PORTS],
  output logic [IDX_W-1:0]     owner,
  output logic                 timeout_pulse
);

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [CNT_W-1:0] hold_cnt;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] next_ptr;
  logic             owner_wants;
  logic             keep;

  rr_priority_picker #(
    .NUM_PORTS(NUM_PORTS)
  ) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  // Ownership is retained only while the owner keeps both req and hold and the hold budget remains.
  always_comb begin
    owner_wants   = (state == ST_OWNED) && req[owner] && hold[owner];
    keep          = owner_wants && (hold_cnt < CNT_W'(MAX_HOLD - 1));
    timeout_pulse = owner_wants && (hold_cnt == CNT_W'(MAX_HOLD - 1));
    next_ptr      = (pick_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : pick_idx + IDX_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      grant    <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
    end else if (keep) begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end else if (pick_valid) begin
      state    <= ST_OWNED;
      owner    <= pick_idx;
      grant    <= NUM_PORTS'(1) << pick_idx;
      rr_ptr   <= next_ptr;
      hold_cnt <= '0;
    end else begin
      state    <= ST_IDLE;
      grant    <= '0;
      hold_cnt <= '0;
    end
  end

  // Memory sees the owner's packet only while it is granted and still requesting.
  always_comb begin
    mem_req_out = '0;
    if (grant[owner] && req[owner]) mem_req_out = mem_req_in[owner];
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      rdata[i] = (grant[i] && !mem_req_in[i].wen) ? mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level reference model of the arbitration rules.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int MH = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N-1:0]   hold;
  mem_req_t       mreq [N];
  logic [31:0]    mem_rdata;
  mem_req_t       mem_req_out;
  logic [N-1:0]   grant;
  logic [31:0]    rdata [N];
  logic [1:0]     owner;
  logic           timeout_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit m_owned;
  int m_owner;
  int m_ptr;
  int m_cnt;

  logic [31:0] mem [16];

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_PORTS(N), .MAX_HOLD(MH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .hold          (hold),
    .mem_req_in    (mreq),
    .mem_rdata     (mem_rdata),
    .mem_req_out   (mem_req_out),
    .grant         (grant),
    .rdata         (rdata),
    .owner         (owner),
    .timeout_pulse (timeout_pulse)
  );

  // stand-in for the single-port data memory
  always @(posedge clk) begin
    if (mem_req_out.wen) mem[mem_req_out.addr[3:0]] <= mem_req_out.wdata;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (r[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owned = 0;
    m_owner = 0;
    m_ptr   = 0;
    m_cnt   = 0;
  endtask

  task automatic model_edge();
    int w;
    if (m_owned && req[m_owner] && hold[m_owner] && m_cnt < MH - 1) begin
      m_cnt++;
    end else begin
      w = rr_pick(req, m_ptr);
      if (w >= 0) begin
        m_owned = 1;
        m_owner = w;
        m_ptr   = (w + 1) % N;
        m_cnt   = 0;
      end else begin
        m_owned = 0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] eg;
    logic [63:0]  eo;
    logic [31:0]  er;
    logic         et;
    eg = m_owned ? (N'(1) << m_owner) : '0;
    chk("grant", 64'(grant), 64'(eg));
    if (m_owned) chk("owner", 64'(owner), 64'(m_owner));
    eo = (m_owned && req[m_owner]) ? 64'(mreq[m_owner]) : 64'(0);
    chk("mem_req_out", 64'(mem_req_out), eo);
    for (int i = 0; i < N; i++) begin
      er = (m_owned && m_owner == i && !mreq[i].wen) ? mem_rdata : 32'h0;
      chk($sformatf("rdata%0d", i), 64'(rdata[i]), 64'(er));
    end
    et = m_owned && req[m_owner] && hold[m_owner] && (m_cnt == MH - 1);
    chk("timeout_pulse", 64'(timeout_pulse), 64'(et));
  endtask

  // called just after a rising edge: check mid-cycle, advance through the next edge
  task automatic cycle();
    #4;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    hold  = '0;
    model_reset();
    #1;
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_out", 64'(mem_req_out), 64'(0));
    chk("rst_owner", 64'(owner), 64'(0));
    chk("rst_timeout", 64'(timeout_pulse), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    hold      = '0;
    mem_rdata = 32'h0;
    for (int i = 0; i < N; i++) mreq[i] = '0;
    do_reset();

    // two simultaneous requesters, served in order, then idle
    req = 4'b0110;
    cycle();
    chk("two_req_g1", 64'(grant), 64'(4'b0010));
    req = 4'b0100;
    cycle();
    chk("two_req_g2", 64'(grant), 64'(4'b0100));
    req = 4'b0000;
    cycle();
    chk("two_req_idle", 64'(grant), 64'(0));

    // hold runs into the budget while port 3 waits
    do_reset();
    req  = 4'b1001;
    hold = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (c <= 8) begin
        chk($sformatf("hold_grant_c%0d", c), 64'(grant), 64'((c < 8) ? 4'b0001 : 4'b1000));
        chk($sformatf("hold_to_c%0d", c), 64'(timeout_pulse), 64'(c == 7));
      end
    end

    // all ports requesting, no hold: back-to-back rotation
    do_reset();
    req  = 4'b1111;
    hold = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk($sformatf("rot_c%0d", c), 64'(grant), 64'(N'(1) << (c % N)));
    end

    // owner 2 drops req with a write pending: nothing reaches memory
    do_reset();
    mreq[0] = '{wen: 1'b1, addr: 16'd5, wdata: 32'h1234_5678};
    req = 4'b0001;
    cycle();
    cycle();
    req = 4'b0000;
    cycle();
    chk("seed_write", 64'(mem[5]), 64'(32'h1234_5678));
    mreq[2] = '{wen: 1'b1, addr: 16'd5, wdata: 32'hCAFE_F00D};
    req = 4'b0100;
    cycle();
    req = 4'b0000;
    #1;
    chk("drop_out", 64'(mem_req_out), 64'(0));
    chk("drop_grant_held", 64'(grant), 64'(4'b0100));
    cycle();
    chk("drop_grant_gone", 64'(grant), 64'(0));
    chk("drop_mem", 64'(mem[5]), 64'(32'h1234_5678));

    // read by port 3
    do_reset();
    mreq[3]   = '{wen: 1'b0, addr: 16'd9, wdata: 32'h0};
    mem_rdata = 32'hDEAD_BEEF;
    req = 4'b1000;
    cycle();
    #1;
    chk("rd3", 64'(rdata[3]), 64'(32'hDEAD_BEEF));
    for (int i = 0; i < 3; i++) chk($sformatf("rd_other%0d", i), 64'(rdata[i]), 64'(0));
    req = 4'b0000;
    cycle();

    // asynchronous reset in the middle of port 1's hold
    do_reset();
    mreq[1] = '{wen: 1'b1, addr: 16'd3, wdata: 32'h0BAD_0BAD};
    req  = 4'b0010;
    hold = 4'b0010;
    cycle();
    cycle();
    chk("pre_rst_grant", 64'(grant), 64'(4'b0010));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_grant", 64'(grant), 64'(0));
    chk("async_out", 64'(mem_req_out), 64'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 4'b1010;
    hold  = 4'b0000;
    #1;
    chk("no_early_grant", 64'(grant), 64'(0));
    cycle();
    chk("regrant_rr0", 64'(grant), 64'(4'b0010));

    // randomized traffic with occasional asynchronous reset
    do_reset();
    for (int c = 0; c < 600; c++) begin
      req  = 4'($urandom) & 4'($urandom | $urandom);
      hold = 4'($urandom | $urandom);
      for (int i = 0; i < N; i++) begin
        mreq[i] = '{wen: 1'($urandom), addr: 16'($urandom), wdata: $urandom};
      end
      mem_rdata = $urandom;
      if ($urandom_range(0, 59) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("rnd_async_grant", 64'(grant), 64'(0));
        chk("rnd_async_out", 64'(mem_req_out), 64'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end else begin
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
